// File: rtl/mux_arb_if.sv
// rtl/mux_arb_if.sv - handshake bundle between N producers, the mux_arb block and its single consumer
interface mux_arb_if #(
    parameter int LARGURA = 32,
    parameter int N       = 4
);
    localparam int SELW = $clog2(N);

    logic [N*LARGURA-1:0] entr;
    logic [N-1:0]         entr_valid;
    logic [N-1:0]         entr_pronto;
    logic [SELW-1:0]      sel;
    logic                 modo;
    logic [LARGURA-1:0]   saida;
    logic                 saida_valid;
    logic                 saida_pronto;
    logic [SELW-1:0]      saida_origem;

    modport master (
        output entr, entr_valid, sel, modo, saida_pronto,
        input  entr_pronto, saida, saida_valid, saida_origem
    );

    modport slave (
        input  entr, entr_valid, sel, modo, saida_pronto,
        output entr_pronto, saida, saida_valid, saida_origem
    );
endinterface

// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - N-channel registered mux with valid/ready handshake; MUX_ARB_RR_EN adds round-robin mode
module mux_arb #(
    parameter int LARGURA = 32,
    parameter int N       = 4
) (
    input logic        clk,
    input logic        rst_n,
    mux_arb_if.slave   bus
);
    localparam int SELW = $clog2(N);

    typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] saida_q, saida_d;
    logic [SELW-1:0]    origem_q, origem_d;

    logic               carga;
    logic               chan_ok;
    logic               transfer;
    logic [SELW-1:0]    chan;
    logic [LARGURA-1:0] entr_ch [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign entr_ch[i] = bus.entr[i*LARGURA +: LARGURA];
    end

    assign carga = (estado_q == VAZIO) | bus.saida_pronto;

`ifdef MUX_ARB_RR_EN
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            grant_found;
    logic [SELW-1:0] grant_idx;

    // First valid channel searching ptr, ptr+1, ... with wrap at N.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_found && bus.entr_valid[SELW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = SELW'(idx);
            end
        end
    end

    always_comb begin
        if (bus.modo) begin
            chan    = grant_idx;
            chan_ok = grant_found;
        end else begin
            chan    = bus.sel;
            chan_ok = 32'(bus.sel) < N;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (transfer && bus.modo) begin
            ptr_d = (32'(chan) == N - 1) ? '0 : chan + 1'b1;
        end
    end
`else
    wire unused_modo = bus.modo;

    always_comb begin
        chan    = bus.sel;
        chan_ok = 32'(bus.sel) < N;
    end
`endif

    // Ready never looks at data, only at the chosen channel and the load enable.
    always_comb begin
        bus.entr_pronto = '0;
        if (chan_ok && carga) bus.entr_pronto[chan] = 1'b1;
    end

    assign transfer = chan_ok & carga & bus.entr_valid[chan];

    always_comb begin
        estado_d = estado_q;
        saida_d  = saida_q;
        origem_d = origem_q;
        if (transfer) begin
            estado_d = CHEIO;
            saida_d  = entr_ch[chan];
            origem_d = chan;
        end else if (bus.saida_pronto) begin
            estado_d = VAZIO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= VAZIO;
            saida_q  <= '0;
            origem_q <= '0;
`ifdef MUX_ARB_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            estado_q <= estado_d;
            saida_q  <= saida_d;
            origem_q <= origem_d;
`ifdef MUX_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign bus.saida        = saida_q;
    assign bus.saida_valid  = (estado_q == CHEIO);
    assign bus.saida_origem = origem_q;
endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - directed self-checking bench for mux_arb (N=4 and N=3 instances)
module tb_mux_arb;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mux_arb_if #(.LARGURA(32), .N(4)) if4 ();
    mux_arb_if #(.LARGURA(32), .N(3)) if3 ();

    mux_arb #(.LARGURA(32), .N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mux_arb #(.LARGURA(32), .N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w4(input int i, input logic [31:0] v);
        if4.entr[i*32 +: 32] = v;
    endtask

    task automatic set_w3(input int i, input logic [31:0] v);
        if3.entr[i*32 +: 32] = v;
    endtask

    task automatic idle_inputs();
        if4.entr = '0; if4.entr_valid = '0; if4.sel = '0; if4.modo = 1'b0; if4.saida_pronto = 1'b1;
        if3.entr = '0; if3.entr_valid = '0; if3.sel = '0; if3.modo = 1'b0; if3.saida_pronto = 1'b1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (if4.saida !== 32'h0 || if4.saida_valid !== 1'b0 || if4.saida_origem !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_initial: saida=%h valid=%b origem=%0d, required 0/0/0", if4.saida, if4.saida_valid, if4.saida_origem);
        end
        rst_n = 1'b1;
        if4.sel = 2'd0; if4.entr_valid = 4'b0001; set_w4(0, 32'hDEAD0000); if4.saida_pronto = 1'b0;
        tick();
        n_checks++;
        if (if4.saida_valid !== 1'b1 || if4.saida !== 32'hDEAD0000) begin
            n_fail++;
            $display("FAIL reset_preload: valid=%b saida=%h, required 1/DEAD0000", if4.saida_valid, if4.saida);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (if4.saida !== 32'h0 || if4.saida_valid !== 1'b0 || if4.saida_origem !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_async: saida=%h valid=%b origem=%0d, required 0/0/0", if4.saida, if4.saida_valid, if4.saida_origem);
        end
        #1 rst_n = 1'b1;
        if4.sel = 2'd2; if4.entr_valid = 4'b0100; set_w4(2, 32'hCAFE0002); if4.saida_pronto = 1'b1;
        tick();
        n_checks++;
        if (if4.saida !== 32'hCAFE0002 || if4.saida_origem !== 2'd2 || if4.saida_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_accept: saida=%h origem=%0d valid=%b, required CAFE0002/2/1", if4.saida, if4.saida_origem, if4.saida_valid);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        if4.sel = 2'd1; if4.entr_valid = 4'b0010; set_w4(1, 32'h11110000); if4.saida_pronto = 1'b0;
        #1;
        n_checks++;
        if (if4.entr_pronto !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_pronto_empty: entr_pronto=%b, required 0010", if4.entr_pronto);
        end
        tick();
        set_w4(1, 32'h11110001);
        #1;
        n_checks++;
        if (if4.saida !== 32'h11110000 || if4.saida_origem !== 2'd1 || if4.entr_pronto !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_first_load: saida=%h origem=%0d pronto=%b, required 11110000/1/0000", if4.saida, if4.saida_origem, if4.entr_pronto);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (if4.saida !== 32'h11110000 || if4.saida_valid !== 1'b1 || if4.entr_pronto !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: saida=%h valid=%b pronto=%b, required 11110000/1/0000", c, if4.saida, if4.saida_valid, if4.entr_pronto);
            end
        end
        if4.saida_pronto = 1'b1;
        #1;
        n_checks++;
        if (if4.entr_pronto !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release_pronto: entr_pronto=%b, required 0010", if4.entr_pronto);
        end
        tick();
        n_checks++;
        if (if4.saida !== 32'h11110001 || if4.saida_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stream0: saida=%h valid=%b, required 11110001/1", if4.saida, if4.saida_valid);
        end
        set_w4(1, 32'h11110002);
        tick();
        n_checks++;
        if (if4.saida !== 32'h11110002 || if4.saida_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stream1: saida=%h valid=%b, required 11110002/1", if4.saida, if4.saida_valid);
        end
        if4.entr_valid = 4'b0000;
        tick();
        n_checks++;
        if (if4.saida_valid !== 1'b0 || if4.saida !== 32'h11110002 || if4.saida_origem !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%b saida=%h origem=%0d, required 0/11110002/1", if4.saida_valid, if4.saida, if4.saida_origem);
        end
    endtask

    task automatic test_invalid_select();
        reset_dut();
        if3.sel = 2'd3; if3.entr_valid = 3'b111;
        set_w3(0, 32'h30000000); set_w3(1, 32'h30000001); set_w3(2, 32'h30000002);
        #1;
        n_checks++;
        if (if3.entr_pronto !== 3'b000) begin
            n_fail++;
            $display("FAIL inv_sel_pronto: entr_pronto=%b, required 000", if3.entr_pronto);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (if3.saida_valid !== 1'b0 || if3.entr_pronto !== 3'b000) begin
                n_fail++;
                $display("FAIL inv_sel_idle[%0d]: valid=%b pronto=%b, required 0/000", c, if3.saida_valid, if3.entr_pronto);
            end
        end
        if3.sel = 2'd2;
        #1;
        n_checks++;
        if (if3.entr_pronto !== 3'b100) begin
            n_fail++;
            $display("FAIL top_sel_pronto: entr_pronto=%b, required 100", if3.entr_pronto);
        end
        tick();
        n_checks++;
        if (if3.saida !== 32'h30000002 || if3.saida_origem !== 2'd2 || if3.saida_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL top_sel_load: saida=%h origem=%0d valid=%b, required 30000002/2/1", if3.saida, if3.saida_origem, if3.saida_valid);
        end
    endtask

`ifdef MUX_ARB_RR_EN
    task automatic test_round_robin();
        logic [1:0] exp_seq [6];
        logic [3:0] vpat    [5];
        logic [1:0] vexp    [5];
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
        exp_seq[3] = 2'd3; exp_seq[4] = 2'd0; exp_seq[5] = 2'd1;
        // Continues from ptr=2: 1001 -> 3, 1001 -> 0, 0100 -> 2, 0010 -> 1 (ptr 3 wraps), 0011 -> 0 (ptr 2).
        vpat[0] = 4'b1001; vexp[0] = 2'd3;
        vpat[1] = 4'b1001; vexp[1] = 2'd0;
        vpat[2] = 4'b0100; vexp[2] = 2'd2;
        vpat[3] = 4'b0010; vexp[3] = 2'd1;
        vpat[4] = 4'b0011; vexp[4] = 2'd0;
        reset_dut();
        if4.modo = 1'b1; if4.sel = 2'd3; if4.entr_valid = 4'b1111; if4.saida_pronto = 1'b1;
        for (int i = 0; i < 4; i++) set_w4(i, 32'hB0000000 + i);
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if (if4.entr_pronto !== (4'b0001 << exp_seq[c])) begin
                n_fail++;
                $display("FAIL rr_pronto[%0d]: entr_pronto=%b, required channel %0d", c, if4.entr_pronto, exp_seq[c]);
            end
            tick();
            n_checks++;
            if (if4.saida_origem !== exp_seq[c] || if4.saida !== 32'hB0000000 + 32'(exp_seq[c]) || if4.saida_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: origem=%0d saida=%h, required %0d", c, if4.saida_origem, if4.saida, exp_seq[c]);
            end
        end
        for (int c = 0; c < 5; c++) begin
            if4.entr_valid = vpat[c];
            tick();
            n_checks++;
            if (if4.saida_origem !== vexp[c] || if4.saida !== 32'hB0000000 + 32'(vexp[c])) begin
                n_fail++;
                $display("FAIL rr_sparse[%0d]: origem=%0d saida=%h, required %0d", c, if4.saida_origem, if4.saida, vexp[c]);
            end
        end
    endtask
`else
    task automatic test_macro_off();
        reset_dut();
        if4.modo = 1'b1; if4.sel = 2'd2; if4.entr_valid = 4'b1111; if4.saida_pronto = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) set_w4(i, 32'hC0000000 + 32'(c*16 + i));
            #1;
            n_checks++;
            if (if4.entr_pronto !== 4'b0100) begin
                n_fail++;
                $display("FAIL fixed_pronto[%0d]: entr_pronto=%b, required 0100", c, if4.entr_pronto);
            end
            tick();
            n_checks++;
            if (if4.saida_origem !== 2'd2 || if4.saida !== 32'hC0000000 + 32'(c*16 + 2) || if4.saida_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fixed_load[%0d]: origem=%0d saida=%h, required 2/%h", c, if4.saida_origem, if4.saida, 32'hC0000000 + 32'(c*16 + 2));
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_backpressure();
        test_invalid_select();
`ifdef MUX_ARB_RR_EN
        test_round_robin();
`else
        test_macro_off();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-channel, LARGURA-bit registered multiplexer with valid/ready handshake on every input and on the output. It is the next generation of the datapath 4x1 multiplexer. It adds a one-stage output register and backpressure, plus an optional round-robin arbitration mode. It sits between multiple producers (e.g. memory/IO response paths) and a single consumer in the processor datapath.

## Interface
Parameters:
- LARGURA, 32, data width of each channel and of the output
- N, 4, number of input channels (N >= 2, need not be a power of two)
- SELW, $clog2(N), width of select/origin fields (derived; not overridden)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- entr  input  N*LARGURA  channel data; channel i at bits [i*LARGURA +: LARGURA]
- entr_valid  input  N  channel i offers data
- entr_pronto  output  N  channel i data accepted this cycle when entr_valid[i] also high
- sel  input  SELW  channel selected in fixed mode
- modo  input  1  0 = fixed select, 1 = round-robin (effective only with MUX_ARB_RR_EN)
- saida  output  LARGURA  registered output data
- saida_valid  output  1  output register holds data
- saida_pronto  input  1  consumer accepts saida this cycle
- saida_origem  output  SELW  channel index that produced the current saida

## Operation
- Output register states: VAZIO (saida_valid=0) and CHEIO (saida_valid=1).
- Load enable: carga = !saida_valid | saida_pronto.
- Fixed mode (modo=0, or macro absent):
  - entr_pronto[sel] = carga; all other bits are 0.
  - If sel >= N, all entr_pronto are 0 and nothing is accepted.
- Round-robin mode (modo=1, macro present):
  - Internal pointer ptr (SELW bits).
  - Grant goes to the first i with entr_valid[i] = 1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap mod N).
  - entr_pronto[grant] = carga, and only when some valid exists. `sel` is ignored.
- Transfer when entr_valid[c] & entr_pronto[c]. On that edge: saida ← entr[c], saida_origem ← c, saida_valid ← 1.
  - In RR mode, ptr ← (c+1 == N) ? 0 : c+1.
- If there is no transfer and saida_pronto=1 while CHEIO, then saida_valid ← 0. saida and saida_origem hold their old values.
- While CHEIO & !saida_pronto, saida and saida_origem are stable regardless of entr, sel and modo changes.
- ptr changes only on an RR-mode transfer. Switching modo retains ptr.
- entr_pronto depends combinationally on saida_pronto, saida_valid, sel/entr_valid and ptr. It never depends on entr data.

## Timing
- Reset (async assert, any time): saida=0, saida_valid=0, saida_origem=0, ptr=0. In-flight data is discarded. Outputs are valid reset values immediately, not at the next edge.
- Deassertion: the first accept is possible at the first rising edge after rst_n goes high.
- Latency: data accepted at edge k is visible on saida right after edge k.
- Throughput: one transfer per cycle when saida_pronto is held at 1.
- Simultaneous drain and load (CHEIO, saida_pronto=1, transfer): saida is replaced by the new data and saida_valid stays 1. There are no bubbles.
- At most one entr_pronto bit is high in any cycle.

## Configuration
- MUX_ARB_RR_EN defined: round-robin arbiter and ptr register are compiled in, and modo selects the mode.
- MUX_ARB_RR_EN undefined: modo is ignored (port kept, unused), there is no ptr register, and the block always operates in fixed mode.

## Test plan
- Reset: assert rst_n=0 mid-transfer with saida_valid=1 → saida=0, saida_valid=0, saida_origem=0 with no clock edge. Release, then sel=2, entr_valid=4'b0100, entr[2]=32'hCAFE0002 → after 1 edge saida=32'hCAFE0002, saida_origem=2.
- Backpressure: fixed mode, sel=1, entr_valid[1]=1 held, saida_pronto=0 for 3 cycles → entr_pronto[1]=0 after the first load. saida stays at the first word. Raising saida_pronto gives one transfer per cycle afterwards.
- Invalid select: N=3, sel=3, all valid → entr_pronto=0, saida_valid stays 0.
- Round-robin (macro on, modo=1, N=4): all entr_valid=1, saida_pronto=1 for 6 cycles → saida_origem sequence 0,1,2,3,0,1. Then entr_valid=4'b1001 after ptr=2 → grant 3, then 0.
- Sparse RR wrap: ptr=3, entr_valid=4'b0010 → grant 1 and ptr becomes 2. Next grant with entr_valid=4'b0011 goes to channel 0 (search order 2,3,0).
- Macro off: modo=1, sel=2, all valid → only channel 2 is accepted, every cycle.
